// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : uart_pkg                                                         |
// | Brief   : Shared state encoding, default bit period, parity helper.        |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
package uart_pkg;

    localparam int unsigned c_DEFAULT_CLKS_PER_BIT = 868;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LATCH  = 3'd2,
        S_START  = 3'd3,
        S_DATA   = 3'd4,
        S_PARITY = 3'd5,
        S_STOP   = 3'd6
    } tx_state_t;

    // Callers zero-extend narrower words; extra zeros do not change even parity.
    function automatic logic even_parity(input logic [63:0] data);
        return ^data;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : uart_baud_cnt                                                    |
// | Brief   : Bit-period counter, 0..CLKS_PER_BIT-1, pulses bit_done at end.   |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = c_DEFAULT_CLKS_PER_BIT
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic clear,
    output logic bit_done
);

    localparam int unsigned           c_CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0]    c_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);

    logic [c_CNT_W-1:0] r_cnt;

    assign bit_done = (r_cnt == c_LAST);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_cnt <= '0;
        end else if (clear || bit_done) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_fifo_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : uart_fifo_tx                                                     |
// | Brief   : FIFO-draining UART transmitter, 8N1 (8E1 with UART_TX_PARITY_EN) |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
module uart_fifo_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = c_DEFAULT_CLKS_PER_BIT,
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned DATA_WIDTH   = 8
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [ADDR_WIDTH:0]   fifo_count,
    input  logic [DATA_WIDTH-1:0] fifo_r_data,
    output logic                  fifo_r_enable,
    output logic                  txd,
    output logic                  busy
);

    localparam int unsigned        c_IDX_W    = $clog2(DATA_WIDTH + 1);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(DATA_WIDTH - 1);

    tx_state_t             r_state;
    tx_state_t             w_state_nxt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] w_shift_nxt;
    logic [c_IDX_W-1:0]    r_bit_idx;
    logic [c_IDX_W-1:0]    w_bit_idx_nxt;
    logic                  r_txd;
    logic                  w_txd_nxt;
    logic                  r_fifo_r_enable;
    logic                  w_baud_clear;
    logic                  w_bit_done;
    logic                  w_fifo_nonempty;
`ifdef UART_TX_PARITY_EN
    logic                  r_parity;
`endif

    assign w_fifo_nonempty = |fifo_count;
    assign fifo_r_enable   = r_fifo_r_enable;
    assign txd             = r_txd;
    assign busy            = (r_state != S_IDLE);

    uart_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_cnt (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .clear    (w_baud_clear),
        .bit_done (w_bit_done)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_idx_nxt = r_bit_idx;
        w_baud_clear  = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_baud_clear = 1'b1;
                if (w_fifo_nonempty) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                w_baud_clear = 1'b1;
                w_state_nxt  = S_LATCH;
            end
            // Read data from the FIFO is valid now, one cycle after the pop.
            S_LATCH: begin
                w_baud_clear = 1'b1;
                w_shift_nxt  = fifo_r_data;
                w_state_nxt  = S_START;
            end
            S_START: begin
                if (w_bit_done) begin
                    w_bit_idx_nxt = '0;
                    w_state_nxt   = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_done) begin
                    w_shift_nxt   = r_shift >> 1;
                    w_bit_idx_nxt = r_bit_idx + 1'b1;
                    if (r_bit_idx == c_LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_bit_done) begin
                    w_state_nxt = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (w_bit_done) begin
                    w_state_nxt = w_fifo_nonempty ? S_FETCH : S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Line level is decoded from the upcoming state so txd is a clean flop output.
    always_comb begin
        w_txd_nxt = 1'b1;
        case (w_state_nxt)
            S_START:  w_txd_nxt = 1'b0;
            S_DATA:   w_txd_nxt = w_shift_nxt[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: w_txd_nxt = r_parity;
`endif
            default:  w_txd_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state         <= S_IDLE;
            r_shift         <= '0;
            r_bit_idx       <= '0;
            r_txd           <= 1'b1;
            r_fifo_r_enable <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_shift         <= w_shift_nxt;
            r_bit_idx       <= w_bit_idx_nxt;
            r_txd           <= w_txd_nxt;
            r_fifo_r_enable <= (w_state_nxt == S_FETCH);
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_parity <= 1'b0;
        end else if (r_state == S_LATCH) begin
            r_parity <= even_parity(64'(fifo_r_data));
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_fifo_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_uart_fifo_tx                                                  |
// | Brief   : Directed/random bench for uart_fifo_tx with a FIFO + line model. |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_uart_fifo_tx;

    localparam int CPB = 4;
    localparam int AW  = 8;
    localparam int DW  = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NSLOT = DW + 3;
`else
    localparam int NSLOT = DW + 2;
`endif
    localparam int FRAME = NSLOT * CPB;

    logic          CLK         = 1'b0;
    logic          RST_N       = 1'b0;
    logic [AW:0]   fifo_count  = '0;
    logic [DW-1:0] fifo_r_data = '0;
    logic          fifo_r_enable;
    logic          txd;
    logic          busy;

    logic          push_req  = 1'b0;
    logic [DW-1:0] push_data = '0;
    logic [DW-1:0] q[$];
    int            n_pops  = 0;
    int            n_tests = 0;
    int            n_fail  = 0;

    uart_fifo_tx #(
        .CLKS_PER_BIT (CPB),
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW)
    ) dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .fifo_count    (fifo_count),
        .fifo_r_data   (fifo_r_data),
        .fifo_r_enable (fifo_r_enable),
        .txd           (txd),
        .busy          (busy)
    );

    always #5 CLK = ~CLK;

    // Behavioural FIFO: registered read data, count updated on the same edge.
    always @(posedge CLK) begin
        if (push_req) q.push_back(push_data);
        if (fifo_r_enable) begin
            n_pops++;
            if (q.size() != 0) fifo_r_data <= q.pop_front();
        end
        fifo_count <= (AW+1)'(q.size());
    end

    // Line level expected in bit slot k of a frame carrying byte b.
    function automatic logic model_txd(input logic [DW-1:0] b, input int slot);
        if (slot == 0) return 1'b0;
        if (slot <= DW) return b[slot-1];
`ifdef UART_TX_PARITY_EN
        if (slot == DW + 1) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic push(input logic [DW-1:0] b);
        push_req  = 1'b1;
        push_data = b;
        @(negedge CLK);
        push_req  = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_ren"},  32'(fifo_r_enable), 32'd0);
        check({tag, "_txd"},  32'(txd), 32'd1);
    endtask

    task automatic chk_fetch(input string tag);
        check({tag, "_fetch_ren"},  32'(fifo_r_enable), 32'd1);
        check({tag, "_fetch_busy"}, 32'(busy), 32'd1);
        check({tag, "_fetch_txd"},  32'(txd), 32'd1);
    endtask

    task automatic chk_latch(input string tag, input int exp_cnt);
        check({tag, "_latch_ren"}, 32'(fifo_r_enable), 32'd0);
        check({tag, "_latch_txd"}, 32'(txd), 32'd1);
        check({tag, "_latch_cnt"}, 32'(fifo_count), 32'(exp_cnt));
    endtask

    // Called at the negedge inside LATCH; walks every cycle of the frame.
    task automatic run_frame(input string tag, input logic [DW-1:0] b,
                             input int push_at, input logic [DW-1:0] pd);
        for (int i = 0; i < FRAME; i++) begin
            if (i == push_at) begin
                push_req  = 1'b1;
                push_data = pd;
            end
            @(negedge CLK);
            push_req = 1'b0;
            check({tag, "_txd"}, 32'(txd), 32'(model_txd(b, i / CPB)));
            check({tag, "_busy"}, 32'(busy), 32'd1);
        end
    endtask

    initial begin
        logic [DW-1:0] r0, r1, r2;
        int pops0;
        int bad_ren, bad_txd, bad_busy;

        // Reset state
        repeat (3) tick();
        chk_idle("reset");
        RST_N = 1'b1;

        // Empty FIFO for 1000 cycles
        bad_ren = 0; bad_txd = 0; bad_busy = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (fifo_r_enable !== 1'b0) bad_ren++;
            if (txd !== 1'b1) bad_txd++;
            if (busy !== 1'b0) bad_busy++;
        end
        check("empty_ren",  32'(bad_ren), 32'd0);
        check("empty_txd",  32'(bad_txd), 32'd0);
        check("empty_busy", 32'(bad_busy), 32'd0);

        // Single byte 0xA5
        pops0 = n_pops;
        push(8'hA5);
        chk_idle("single_e0");
        tick(); chk_fetch("single");
        tick(); chk_latch("single", 0);
        run_frame("single_a5", 8'hA5, -1, '0);
        tick(); chk_idle("single_end");
        check("single_pops", 32'(n_pops - pops0), 32'd1);

        // Back-to-back 0x00 then 0xFF
        pops0 = n_pops;
        push(8'h00);
        push(8'hFF);
        chk_fetch("b2b1");
        tick(); chk_latch("b2b1", 1);
        run_frame("b2b_00", 8'h00, -1, '0);
        tick(); chk_fetch("b2b2");
        tick(); chk_latch("b2b2", 0);
        run_frame("b2b_ff", 8'hFF, -1, '0);
        tick(); chk_idle("b2b_end");
        check("b2b_pops", 32'(n_pops - pops0), 32'd2);

        // Three random bytes queued together
        r0 = DW'($urandom); r1 = DW'($urandom); r2 = DW'($urandom);
        pops0 = n_pops;
        push(r0); push(r1); push(r2);
        chk_latch("rnd1", 2);
        run_frame("rnd_b0", r0, -1, '0);
        tick(); chk_fetch("rnd2");
        tick(); chk_latch("rnd2", 1);
        run_frame("rnd_b1", r1, -1, '0);
        tick(); chk_fetch("rnd3");
        tick(); chk_latch("rnd3", 0);
        run_frame("rnd_b2", r2, -1, '0);
        tick(); chk_idle("rnd_end");
        check("rnd_pops", 32'(n_pops - pops0), 32'd3);

        // Write arriving mid-frame on a one-byte queue
        r0 = DW'($urandom); r1 = DW'($urandom);
        pops0 = n_pops;
        push(r0);
        chk_idle("wdt_e0");
        tick(); chk_fetch("wdt1");
        tick(); chk_latch("wdt1", 0);
        run_frame("wdt_b0", r0, FRAME / 2, r1);
        tick(); chk_fetch("wdt2");
        tick(); chk_latch("wdt2", 0);
        run_frame("wdt_b1", r1, -1, '0);
        tick(); chk_idle("wdt_end");
        check("wdt_pops", 32'(n_pops - pops0), 32'd2);

`ifdef UART_TX_PARITY_EN
        // Even parity: 0x07 -> 1, 0x03 -> 0
        push(8'h07);
        tick(); chk_fetch("par07");
        tick(); chk_latch("par07", 0);
        run_frame("par_07", 8'h07, -1, '0);
        tick(); chk_idle("par07_end");
        push(8'h03);
        tick(); chk_fetch("par03");
        tick(); chk_latch("par03", 0);
        run_frame("par_03", 8'h03, -1, '0);
        tick(); chk_idle("par03_end");
`endif

        // Asynchronous reset in the middle of the data bits
        pops0 = n_pops;
        push(8'h00);
        tick(); chk_fetch("rst");
        tick(); chk_latch("rst", 0);
        repeat (3 * CPB + 1) tick();
        check("rst_pre_txd",  32'(txd), 32'd0);
        check("rst_pre_busy", 32'(busy), 32'd1);
        #2 RST_N = 1'b0;
        #1;
        check("rst_async_txd",  32'(txd), 32'd1);
        check("rst_async_busy", 32'(busy), 32'd0);
        check("rst_async_ren",  32'(fifo_r_enable), 32'd0);
        repeat (2) tick();
        RST_N = 1'b1;
        bad_txd = 0; bad_busy = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (txd !== 1'b1) bad_txd++;
            if (busy !== 1'b0) bad_busy++;
        end
        check("rst_after_txd",  32'(bad_txd), 32'd0);
        check("rst_after_busy", 32'(bad_busy), 32'd0);
        check("rst_pops", 32'(n_pops - pops0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
